lsu_mem_port: RTL and testbench

Initiator-side memory port that converts single core load/store requests (byte, halfword, word; signed/unsigned) into the word-wide valid/we/mask/resp single-port RAM protocol. It generates byte masks and lane-shifted store data, waits for the RAM response, and returns a lane-extracted, sign- or zero-extended load result. It works with both combinational-response and registered-response RAMs. It sits between the core's load/store stage and an on-chip data RAM, with one transaction outstanding.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 15 +
 rtl/lsu_mem_port.sv | 157 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helper functions for the load/store memory port:
// FSM states, access sizes, error codes, byte-mask and load-lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_ILL = 2'b11} size_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  function automatic logic [3:0] gen_mask(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the store data lets the RAM pick whichever lanes the mask enables.
  function automatic logic [31:0] gen_wdata(input size_e size, input logic [31:0] wdata);
    case (size)
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input size_e size, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    return uns ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-result formatter: selects the byte/halfword lane at the request
// offset and sign- or zero-extends it to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  assign result_o = load_extract(data_i, off_i, size_i, unsigned_i);

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store port: turns core byte/half/word requests into
// masked word accesses on a valid/we/mask/resp RAM and formats the response.
module lsu_mem_port #(
  parameter int ADDRW   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ADDRW-1:0] req_addr_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic [1:0]       rsp_err_o,
  output logic             mem_valid_o,
  output logic             mem_we_o,
  output logic [ADDRW-1:0] mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [3:0]       mem_mask_o,
  input  logic [31:0]      mem_data_i,
  input  logic             mem_resp_i
);
  import lsu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  err_e             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  logic [ADDRW-1:0] addr_q;
  logic             we_q;
  size_e            size_q;
  logic             uns_q;
  logic [3:0]       mask_q;
  logic [31:0]      wdata_q;

  size_e       req_size;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] done_rdata;

  assign req_size   = size_e'(req_size_i);
  assign accept     = (state_q == IDLE) && req_valid_i;
  assign done_rdata = we_q ? 32'h0 : load_data;

  lsu_load_align u_align (
    .data_i     (mem_data_i),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_data)
  );

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rsp_err_d   = ERR_NONE;
          rsp_rdata_d = 32'h0;
          if (req_size == SZ_ILL) begin
            state_d   = RESP;
            rsp_err_d = ERR_SIZE;
          end else if (is_misaligned(req_size, req_addr_i[1:0])) begin
            state_d   = RESP;
            rsp_err_d = ERR_MISALIGN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (mem_resp_i) begin
          state_d     = RESP;
          rsp_rdata_d = done_rdata;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_i) begin
          state_d     = RESP;
          rsp_rdata_d = done_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          rsp_err_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_err_d   = ERR_NONE;
        rsp_rdata_d = 32'h0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_err_q   <= ERR_NONE;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request fields are captured once on accept and drive the RAM side unchanged until the next accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      mask_q  <= 4'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      addr_q  <= req_addr_i;
      we_q    <= req_we_i;
      size_q  <= req_size;
      uns_q   <= req_unsigned_i;
      mask_q  <= gen_mask(req_size, req_addr_i[1:0]);
      wdata_q <= gen_wdata(req_size, req_wdata_i);
    end
  end

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_valid_o = (state_q == ISSUE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_mask_o  = mask_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: byte-addressed reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_lsu_mem_port;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        rsp_valid_o, mem_valid_o, mem_we_o, mem_resp_i;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
  logic [1:0]  rsp_err_o;
  logic [3:0]  mem_mask_o;

  lsu_mem_port #(.ADDRW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o),
    .mem_data_i(mem_data_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired", name);
  endtask

  // RAM device: mode 0 = combinational response, 1 = registered response, 2 = never responds.
  int          ram_mode = 0;
  logic        force_resp = 1'b0;
  logic [31:0] ram [64] = '{default: '0};
  logic        reg_resp_q;
  logic [31:0] reg_data_q;

  always_comb begin
    mem_resp_i = force_resp || (ram_mode == 0 && mem_valid_o) || (ram_mode == 1 && reg_resp_q);
    if (force_resp)         mem_data_i = 32'hA5A5_A5A5;
    else if (ram_mode == 0) mem_data_i = ram[mem_addr_o[7:2]];
    else                    mem_data_i = reg_data_q;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_resp_q <= 1'b0;
      reg_data_q <= '0;
    end else begin
      reg_resp_q <= (ram_mode == 1) && mem_valid_o;
      reg_data_q <= ram[mem_addr_o[7:2]];
      if (mem_valid_o && mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
  end

  // Reference model: byte memory and per-request expectation with cycle schedule.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          acc_cyc;
    int          issue_cyc;
    int          resp_cyc;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] mdata;
  } exp_t;

  logic [7:0] model_mem [256] = '{default: '0};
  exp_t       q[$];
  int         cyc = 0;
  bit         chk_en = 0;
  int         acc_cnt = 0, done_cnt = 0;
  int         acc_log[$];
  logic [31:0] rsp_log[$];

  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata, input int acc);
    exp_t e;
    int n, off;
    logic [31:0] v;
    off = int'(addr[1:0]);
    n = (size == 2'd3) ? 1 : (1 << size);
    e.we = we; e.addr = addr; e.acc_cyc = acc;
    e.mask = '0; e.mdata = '0; e.rdata = '0;
    if (size == 2'd3)        e.err = 2'd3;
    else if (off % n != 0)   e.err = 2'd1;
    else if (ram_mode == 2)  e.err = 2'd2;
    else                     e.err = 2'd0;
    if (e.err == 2'd1 || e.err == 2'd3) begin
      e.issue_cyc = -1;
      e.resp_cyc  = acc;
    end else begin
      e.issue_cyc = acc;
      e.resp_cyc  = (ram_mode == 0) ? acc + 1 : (ram_mode == 1) ? acc + 2 : acc + TIMEOUT + 1;
      for (int i = 0; i < n; i++) e.mask[off + i] = 1'b1;
      for (int i = 0; i < 4; i++) e.mdata[8*i +: 8] = wdata[8*(i % n) +: 8];
    end
    if (e.err == 2'd0) begin
      if (we) begin
        for (int i = 0; i < n; i++) model_mem[int'(addr[7:0]) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(addr[7:0]) + i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Observations of the DUT for the most recent transaction, used by literal checks.
  bit          obs_mv_seen;
  logic [3:0]  obs_mask;
  logic [31:0] obs_mdata, obs_rdata;
  logic [1:0]  obs_err;
  int          obs_lat;
  exp_t        cur;
  bit          has_cur;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      has_cur = (q.size() > 0);
      if (has_cur) cur = q[0];
      check("req_ready", 32'(req_ready_o), 32'(!has_cur));
      check("mem_valid", 32'(mem_valid_o), 32'(has_cur && cur.issue_cyc == cyc));
      check("rsp_valid", 32'(rsp_valid_o), 32'(has_cur && cur.resp_cyc == cyc));
      if (mem_valid_o) begin
        obs_mv_seen = 1;
        obs_mask    = mem_mask_o;
        obs_mdata   = mem_data_o;
      end
      if (has_cur && cur.issue_cyc >= 0 && cyc >= cur.issue_cyc && cyc < cur.resp_cyc) begin
        check("mem_addr", mem_addr_o, cur.addr);
        check("mem_we", 32'(mem_we_o), 32'(cur.we));
        check("mem_mask", 32'(mem_mask_o), 32'(cur.mask));
        if (cyc == cur.issue_cyc && cur.we) check("mem_data", mem_data_o, cur.mdata);
      end
      if (rsp_valid_o) begin
        obs_rdata = rsp_rdata_o;
        obs_err   = rsp_err_o;
        obs_lat   = has_cur ? cyc - cur.acc_cyc + 1 : -1;
        rsp_log.push_back(rsp_rdata_o);
        done_cnt++;
      end
      if (has_cur && cur.resp_cyc == cyc) begin
        check("rsp_rdata", rsp_rdata_o, cur.rdata);
        check("rsp_err", 32'(rsp_err_o), 32'(cur.err));
        void'(q.pop_front());
      end
      if (req_valid_i && req_ready_o) begin
        q.push_back(model(req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i, cyc + 1));
        acc_log.push_back(cyc + 1);
        acc_cnt++;
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_we_i = we; req_addr_i = addr; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata;
  endtask

  task automatic wait_accept(input int target);
    int n = 0;
    while (acc_cnt < target && n < 20) begin @(posedge clk); #1; n++; end
    if (acc_cnt < target) fail_now("accept_wait");
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata);
    int a0, d0, n;
    a0 = acc_cnt; d0 = done_cnt;
    obs_mv_seen = 0; obs_mask = 4'hx; obs_mdata = 'x; obs_rdata = 'x; obs_err = 2'bxx; obs_lat = -1;
    @(posedge clk); #1;
    drive(we, addr, size, uns, wdata);
    req_valid_i = 1'b1;
    wait_accept(a0 + 1);
    req_valid_i = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 40) begin @(posedge clk); #1; n++; end
    if (done_cnt == d0) fail_now("resp_wait");
  endtask

  initial begin
    int d0, s, a0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 32'({mem_valid_o, mem_we_o, mem_mask_o, rsp_valid_o, rsp_err_o}), 32'h0);
    check("reset_addr", mem_addr_o, 32'h0);
    check("reset_rdata", rsp_rdata_o, 32'h0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready_o), 32'h1);
    chk_en = 1;

    // Word store/load, combinational then registered RAM.
    ram_mode = 0;
    txn(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
    check("sw_mask", 32'(obs_mask), 32'hF);
    check("sw_lat_comb", 32'(obs_lat), 32'd2);
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("lw_comb_data", obs_rdata, 32'hDEAD_BEEF);
    check("lw_comb_err", 32'(obs_err), 32'h0);
    ram_mode = 1;
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("lw_reg_data", obs_rdata, 32'hDEAD_BEEF);
    check("lw_reg_lat", 32'(obs_lat), 32'd3);

    // Byte store in the top lane, then signed and unsigned byte loads.
    txn(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080);
    check("sb_mask", 32'(obs_mask), 32'h8);
    check("sb_data", obs_mdata, 32'h8080_8080);
    ram_mode = 0;
    txn(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
    check("lb_signed", obs_rdata, 32'hFFFF_FF80);
    txn(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
    check("lbu", obs_rdata, 32'h0000_0080);

    // Halfword accesses and the error paths.
    txn(1'b1, 32'h10, 2'd2, 1'b0, 32'h8001_1234);
    txn(1'b0, 32'h12, 2'd1, 1'b0, 32'h0);
    check("lh_signed", obs_rdata, 32'hFFFF_8001);
    txn(1'b0, 32'h11, 2'd1, 1'b0, 32'h0);
    check("lh_misalign_err", 32'(obs_err), 32'h1);
    check("lh_misalign_lat", 32'(obs_lat), 32'd1);
    check("lh_misalign_nomem", 32'(obs_mv_seen), 32'h0);
    txn(1'b0, 32'h10, 2'd3, 1'b0, 32'h0);
    check("ill_size_err", 32'(obs_err), 32'h3);
    check("ill_size_rdata", obs_rdata, 32'h0);

    // Timeout, then a late response that must be ignored.
    ram_mode = 2;
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("timeout_err", 32'(obs_err), 32'h2);
    check("timeout_lat", 32'(obs_lat), 32'(TIMEOUT + 2));
    d0 = done_cnt;
    @(posedge clk); #1; force_resp = 1'b1;
    @(posedge clk); #1; force_resp = 1'b0;
    repeat (3) @(posedge clk);
    check("late_resp_ignored", 32'(done_cnt - d0), 32'h0);
    ram_mode = 0;
    txn(1'b0, 32'h10, 2'd1, 1'b1, 32'h0);
    check("after_timeout_lhu", obs_rdata, 32'h0000_1234);

    // Asynchronous reset while waiting on the RAM.
    ram_mode = 2;
    a0 = acc_cnt;
    @(posedge clk); #1;
    drive(1'b0, 32'h24, 2'd2, 1'b0, 32'h1234_5678);
    req_valid_i = 1'b1;
    wait_accept(a0 + 1);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_en = 0;
    rst = 1'b1;
    #1;
    check("async_rst_ctl", 32'({mem_valid_o, mem_we_o, mem_mask_o, rsp_valid_o, rsp_err_o}), 32'h0);
    check("async_rst_addr", mem_addr_o, 32'h0);
    check("async_rst_mdata", mem_data_o, 32'h0);
    check("async_rst_rdata", rsp_rdata_o, 32'h0);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_in_reset", 32'(rsp_valid_o), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_async_rst", 32'(req_ready_o), 32'h1);
    chk_en = 1;
    ram_mode = 0;
    txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    check("lw_after_rst", obs_rdata, 32'h8001_1234);

    // Three loads with req_valid_i held high throughout.
    s  = acc_log.size();
    a0 = acc_cnt;
    d0 = done_cnt;
    rsp_log.delete();
    @(posedge clk); #1;
    drive(1'b0, 32'h10, 2'd0, 1'b1, 32'h0);
    req_valid_i = 1'b1;
    wait_accept(a0 + 1);
    drive(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
    wait_accept(a0 + 2);
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_accept(a0 + 3);
    req_valid_i = 1'b0;
    for (int n = 0; n < 20 && done_cnt < d0 + 3; n++) begin @(posedge clk); #1; end
    check("b2b_count", 32'(done_cnt - d0), 32'd3);
    if (acc_log.size() >= s + 3) begin
      check("b2b_gap0", 32'(acc_log[s+1] - acc_log[s]), 32'd3);
      check("b2b_gap1", 32'(acc_log[s+2] - acc_log[s+1]), 32'd3);
    end else begin
      fail_now("b2b_accepts");
    end
    if (rsp_log.size() >= 3) begin
      check("b2b_rsp0", rsp_log[0], 32'h0000_0034);
      check("b2b_rsp1", rsp_log[1], 32'h0000_8001);
      check("b2b_rsp2", rsp_log[2], 32'h8001_1234);
    end else begin
      fail_now("b2b_responses");
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
